// File: rtl/music_pkg.sv
// music_pkg: shared widths, song-table markers, song bases and sequencer state encoding
package music_pkg;
    localparam int NOTE_W = 6;
    localparam int DUR_W = 6;
    localparam int ROM_ADDR_W = 9;
    localparam logic [NOTE_W-1:0] REST_NOTE = '0;
    localparam logic [DUR_W-1:0] END_MARKER = '0;
    localparam logic [ROM_ADDR_W-1:0] SONG0_BASE = '0;
    localparam logic [ROM_ADDR_W-1:0] SONG1_BASE = {1'b1, {(ROM_ADDR_W-1){1'b0}}};
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP, DONE} seq_state_t;
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: song ROM read bus; data returns one cycle after the address
interface note_sequencer_if #(
    parameter int ADDR_W = music_pkg::ROM_ADDR_W,
    parameter int DATA_W = music_pkg::NOTE_W + music_pkg::DUR_W
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    modport master(output rom_addr, input rom_data);
    modport slave(input rom_addr, output rom_data);
endinterface

// File: rtl/tick_divider.sv
// tick_divider: enable-gated prescaler giving a duration tick and a once-per-second tick
module tick_divider #(
    parameter int DIV = 10,
    parameter int SEC_DIV = 16
) (
    input  logic clk,
    input  logic RESET_N,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic sec_tick
);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW = SEC_DIV > 1 ? $clog2(SEC_DIV) : 1;
    logic [PW-1:0] pre;
    logic [SW-1:0] sec;
    assign tick = en && pre == PW'(DIV - 1);
    assign sec_tick = tick && sec == SW'(SEC_DIV - 1);
    // pausing holds the count so a resumed note keeps its partial tick
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pre <= '0;
            sec <= '0;
        end else if (clr) begin
            pre <= '0;
            sec <= '0;
        end else if (en) begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) sec <= sec_tick ? '0 : sec + 1'b1;
        end
    end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: walks a {note,duration} song ROM and presents timed fullnote codes,
// with play/pause, song select, end-of-song and an elapsed-seconds count
module note_sequencer import music_pkg::*; #(
    parameter int CLK_HZ = 100_000_000,
    parameter int TICK_HZ = 16,
    parameter int ADDR_W = ROM_ADDR_W
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              play,
    input  logic              song_sel,
    note_sequencer_if.master  rom,
    output logic [NOTE_W-1:0] fullnote,
    output logic              note_strobe,
    output logic              playing,
    output logic              song_done,
    output logic [11:0]       elapsed_sec
);
    logic [1:0] play_sync, sel_sync;
    logic sel_prev, play_s, song_chg, tick, sec_tick, strobe_nx;
    seq_state_t state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [NOTE_W-1:0] note, note_nx, rom_note;
    logic [DUR_W-1:0] dur, dur_nx, rom_dur;

    assign play_s = play_sync[1];
    assign song_chg = sel_sync[1] ^ sel_prev;
    assign {rom_note, rom_dur} = rom.rom_data;
    assign rom.rom_addr = addr;
    assign fullnote = play_s ? note : REST_NOTE;
    assign playing = state == PLAY || state == GAP;
    assign song_done = state == DONE;

    // synchronisers keep sampling through reset so play is already seen on release
    always_ff @(posedge clk) begin
        play_sync <= {play_sync[0], play};
        sel_sync <= {sel_sync[0], song_sel};
    end

    tick_divider #(.DIV(CLK_HZ / TICK_HZ), .SEC_DIV(TICK_HZ)) u_div (
        .clk(clk), .RESET_N(RESET_N), .en(play_s), .clr(song_chg), .tick(tick), .sec_tick(sec_tick)
    );

    always_comb begin
        state_nx = state;
        addr_nx = addr;
        note_nx = note;
        dur_nx = dur;
        strobe_nx = 1'b0;
        if (song_chg) begin
            state_nx = IDLE;
            addr_nx = {sel_sync[1], {(ADDR_W-1){1'b0}}};
            note_nx = REST_NOTE;
            dur_nx = '0;
        end else if (play_s) begin
            case (state)
                IDLE: state_nx = FETCH;
                FETCH: state_nx = WAIT;
                WAIT: if (rom_dur == END_MARKER) state_nx = DONE;
                      else begin
                          note_nx = rom_note;
                          dur_nx = rom_dur - 1'b1;
                          strobe_nx = 1'b1;
                          state_nx = PLAY;
                      end
                PLAY: if (tick) begin
                          if (dur == '0) begin
                              note_nx = REST_NOTE;
                              state_nx = GAP;
                          end else dur_nx = dur - 1'b1;
                      end
                GAP: if (tick) begin
                         addr_nx = {addr[ADDR_W-1], addr[ADDR_W-2:0] + 1'b1};
                         state_nx = FETCH;
                     end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            addr <= '0;
            note <= REST_NOTE;
            dur <= '0;
            note_strobe <= 1'b0;
            sel_prev <= 1'b0;
            elapsed_sec <= '0;
        end else begin
            state <= state_nx;
            addr <= addr_nx;
            note <= note_nx;
            dur <= dur_nx;
            note_strobe <= strobe_nx;
            sel_prev <= sel_sync[1];
            elapsed_sec <= song_chg ? '0 :
                           (sec_tick && playing && elapsed_sec != 12'hFFF) ? elapsed_sec + 1'b1 : elapsed_sec;
        end
    end
endmodule
